slc3_mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the single synchronous BRAM used by SLC-3 (BRAM has output register).

---
 rtl/slc3_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter
//   Arbiter and sequencer for the single synchronous BRAM of the SLC-3.
//   Port 0 is the CPU memory path (MAR/MDR) and port 1 is the memory-init/debug loader.
//   Only one access is in flight at a time. Simultaneous requests are resolved
//   round-robin. The read wait states of the BRAM are inserted here, so a requester
//   only holds req until it sees its done pulse.
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   req0/req1             per-port request, held until the matching done
//   we0/we1               1 = write, 0 = read (stable while req is high)
//   addr0/addr1           per-port address (stable while req is high)
//   wdata0/wdata1         per-port write data (stable while req is high)
//   done0/done1           one-cycle completion pulse
//   rdata0/rdata1         last read result per port, held until that port's next read
//   busy                  high whenever the sequencer is not idle
//   gnt_id                port owning the current transaction (valid while busy)
//   mem_ena/mem_wea       BRAM enable / write enable
//   mem_addr/mem_din      registered BRAM address / write data
//   mem_dout              BRAM read data (from the BRAM output register)
module slc3_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              gnt_id,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic             last_gnt;
  logic             op_we;
  logic [CNT_W-1:0] wait_cnt;
  logic             pick;

  // Winner among current requests. On a tie, the port that did not win last time wins.
  assign pick = (req0 && req1) ? ~last_gnt : req1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      gnt_id   <= 1'b0;
      mem_ena  <= 1'b0;
      mem_wea  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      last_gnt <= 1'b1;   // makes port 0 win the first tie
      op_we    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_id   <= pick;
            last_gnt <= pick;
            op_we    <= pick ? we1 : we0;
            mem_addr <= pick ? addr1 : addr0;
            mem_din  <= pick ? wdata1 : wdata0;
            // Outputs are registered, so the strobes for the ISSUE cycle are set here.
            mem_ena  <= 1'b1;
            mem_wea  <= pick ? we1 : we0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          mem_wea <= 1'b0;
          if (op_we) begin
            mem_ena <= 1'b0;
            done0   <= ~gnt_id;
            done1   <= gnt_id;
            state   <= DONE;
          end else begin
            // Keep the enable high so the BRAM output register is loaded.
            wait_cnt <= CNT_W'(1);
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == CNT_W'(RD_LAT)) begin
            if (gnt_id) rdata1 <= mem_dout;
            else        rdata0 <= mem_dout;
            mem_ena  <= 1'b0;
            done0    <= ~gnt_id;
            done1    <= gnt_id;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb_slc3_mem_arbiter
//   Drives slc3_mem_arbiter against a behavioural BRAM and compares every cycle
//   against a transaction-timeline reference model.
module tb_slc3_mem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk;
  logic        srst;
  logic        preload;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic        done0, done1, busy, gnt_id, mem_ena, mem_wea;
  logic [15:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

  slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(srst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .gnt_id(gnt_id), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 3) ? 16'h1234 : {b, ~b};
  endfunction

  // Behavioural BRAM: synchronous read followed by RD_LAT-1 output stages, all gated by enable.
  logic [15:0] bram [256];
  logic [15:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_val(i);
    end else if (mem_ena) begin
      if (mem_wea) bram[mem_addr[7:0]] <= mem_din;
      pipe[0] <= bram[mem_addr[7:0]];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_dout = pipe[RD_LAT-1];

  // Reference model: a transaction is a timeline t = 1..dl after its grant edge;
  // t==1 is the issue cycle, t==dl the done cycle.
  bit          m_active, m_owner, m_we, m_last;
  int          m_t, m_dl;
  logic [15:0] m_addr, m_wdata, m_maddr, m_mdin;
  logic [15:0] m_rdata [2];
  logic [15:0] m_mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit pk;
    if (srst) begin
      // A write whose issue cycle ends at this edge still lands in the BRAM.
      if (m_active && m_t == 1 && m_we) m_mem[m_addr[7:0]] = m_wdata;
      m_active = 0; m_owner = 0; m_last = 1;
      m_rdata[0] = 16'h0; m_rdata[1] = 16'h0;
      m_maddr = 16'h0; m_mdin = 16'h0;
    end else if (m_active) begin
      if (m_t == m_dl) begin
        m_active = 0;
        $display("txn port=%0d %s addr=%h data=%h", m_owner, m_we ? "WR" : "RD", m_addr,
                 m_we ? m_wdata : m_rdata[m_owner]);
      end else begin
        if (m_t == 1 && m_we) m_mem[m_addr[7:0]] = m_wdata;
        if (!m_we && m_t == m_dl - 1) m_rdata[m_owner] = m_mem[m_addr[7:0]];
        m_t++;
      end
    end else if (req[0] || req[1]) begin
      pk = (req[0] && req[1]) ? !m_last : req[1];
      m_owner = pk; m_last = pk; m_we = we[pk];
      m_addr = addr[pk]; m_wdata = wdata[pk];
      m_maddr = addr[pk]; m_mdin = wdata[pk];
      m_active = 1; m_t = 1;
      m_dl = m_we ? 2 : RD_LAT + 2;
    end
  endtask

  function automatic bit exp_done(input int p);
    return m_active && m_t == m_dl && m_owner == 1'(p);
  endfunction

  task automatic compare_all();
    chk("busy", 32'(busy), 32'(m_active));
    if (m_active) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    chk("done0", 32'(done0), 32'(exp_done(0)));
    chk("done1", 32'(done1), 32'(exp_done(1)));
    chk("rdata0", 32'(rdata0), 32'(m_rdata[0]));
    chk("rdata1", 32'(rdata1), 32'(m_rdata[1]));
    chk("mem_ena", 32'(mem_ena), 32'(m_active && m_t < m_dl));
    chk("mem_wea", 32'(mem_wea), 32'(m_active && m_t == 1 && m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
    chk("mem_din", 32'(mem_din), 32'(m_mdin));
  endtask

  // One clock: model follows the edge, outputs are checked mid-cycle, new stimulus goes in after.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_op(input int p, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int exp_lat);
    int n;
    bit seen;
    req = 2'b00;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      step();
      n++;
      seen = (p == 0) ? done0 : done1;
    end
    chk("op_latency", 32'(n), 32'(exp_lat));
    req[p] = 1'b0;
    step();
  endtask

  task automatic new_op(input int p);
    req[p] = 1'b1;
    we[p] = 1'($urandom_range(0, 1));
    addr[p] = 16'($urandom_range(0, 31));
    wdata[p] = 16'($urandom);
  endtask

  initial begin
    int nev, last_p, last_cyc, p, cnt;
    bit ed;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    m_active = 0; m_owner = 0; m_we = 0; m_last = 1; m_t = 0; m_dl = 0;
    m_addr = 0; m_wdata = 0; m_maddr = 0; m_mdin = 0;
    m_rdata[0] = 0; m_rdata[1] = 0;

    // Reset held with both ports requesting reads.
    srst = 1; preload = 1;
    req = 2'b11; we = 2'b00;
    addr[0] = 16'h0003; addr[1] = 16'h0010; wdata[0] = 16'h0; wdata[1] = 16'h0;
    step(); preload = 0;
    step(); step();
    srst = 0;

    // Both held: first winner port 0, then strict alternation at fixed spacing.
    nev = 0; last_p = -1; last_cyc = 0;
    for (int k = 0; k < 60 && nev < 4; k++) begin
      step();
      if (done0 || done1) begin
        p = done1 ? 1 : 0;
        if (nev == 0) chk("first_gnt", 32'(p), 32'(0));
        else begin
          chk("alternate", 32'(p), 32'(1 - last_p));
          chk("spacing", 32'(cyc - last_cyc), 32'(RD_LAT + 3));
        end
        last_p = p; last_cyc = cyc; nev++;
      end
    end
    chk("alt_events", 32'(nev), 32'(4));
    req = 2'b00;
    step();

    // Port 0 write then read back; port 1 read of a preloaded location.
    do_op(0, 1'b1, 16'h0010, 16'hBEEF, 2);
    do_op(0, 1'b0, 16'h0010, 16'h0000, RD_LAT + 2);
    chk("rd_beef", 32'(rdata0), 32'h0000BEEF);
    do_op(1, 1'b0, 16'h0003, 16'h0000, RD_LAT + 2);
    chk("rd_1234", 32'(rdata1), 32'h00001234);

    // Port 1 read aborted by reset while waiting on the BRAM.
    req = 2'b10; we[1] = 1'b0; addr[1] = 16'h0010;
    step(); step();
    srst = 1; req = 2'b00;
    step();
    srst = 0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done1) cnt++;
    end
    chk("rst_no_done", 32'(cnt), 32'(0));
    chk("rst_idle", 32'(busy), 32'(0));

    // Randomised requesters with occasional resets.
    for (int k = 0; k < 800; k++) begin
      step();
      srst = ($urandom_range(0, 99) == 0);
      for (int q = 0; q < 2; q++) begin
        ed = exp_done(q);
        if (!req[q]) begin
          if ($urandom_range(0, 99) < 30) new_op(q);
        end else if (ed) begin
          if ($urandom_range(0, 1) == 1) req[q] = 1'b0;
          else new_op(q);
        end
      end
    end
    srst = 0; req = 2'b00;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
